// File: rtl/bus_pkg.sv
// Shared bus definitions: default width, IO window base, idle address, initiator FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bus_pkg;

  localparam int          BUS_BITS      = 32;
  localparam logic [31:0] IO_BASE       = 32'hFFFF_F000;
  localparam logic [31:0] BUS_IDLE_ADDR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } init_state_t;

endpackage

// File: rtl/bus_initiator.sv
// Bus initiator: turns one valid/ready request into a WAIT_CYCLES-long bus cycle on ABUS/DBUS/WE, then a 1-cycle response.
// Latency: rsp_valid is seen WAIT_CYCLES+1 edges after the accept edge; one transaction per WAIT_CYCLES+2 cycles.
// Backpressure: req_ready is high only in IDLE; requests are held off while busy. INIT_ALIGN_CHECK_EN rejects misaligned requests.
module bus_initiator
  import bus_pkg::*;
#(
  parameter int               BITS        = BUS_BITS,
  parameter int               WAIT_CYCLES = 1,
  parameter logic [BITS-1:0]  IDLE_ADDR   = BITS'(BUS_IDLE_ADDR)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [BITS-1:0] req_addr,
  input  logic [BITS-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [BITS-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic [BITS-1:0] ABUS,
  inout  wire  [BITS-1:0] DBUS,
  output logic            WE
);

  localparam int            CW       = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  init_state_t     state;
  logic [CW-1:0]   cnt;
  logic            we_q;
  logic [BITS-1:0] wdata_q;
  logic            dbus_oe;
  logic            misaligned;

  // Misaligned requests are only special when the alignment check is built in.
  always_comb begin
    misaligned = 1'b0;
`ifdef INIT_ALIGN_CHECK_EN
    misaligned = (req_addr[1:0] != 2'b00);
`endif
  end

  // Data bus is driven purely from registered state, so req_* never reaches the bus combinationally.
  assign DBUS = dbus_oe ? wdata_q : {BITS{1'bz}};

  // Transaction FSM with registered bus controls and response outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      ABUS      <= IDLE_ADDR;
      WE        <= 1'b0;
      dbus_oe   <= 1'b0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          rsp_valid <= 1'b0;
          if (req_valid) begin
            req_ready <= 1'b0;
            we_q      <= req_we;
            wdata_q   <= req_wdata;
            if (misaligned) begin
              // Rejected without touching the bus; respond on the next cycle.
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
              rsp_err   <= 1'b1;
            end else begin
              state   <= ST_BUS;
              cnt     <= CNT_INIT;
              ABUS    <= req_addr;
              WE      <= req_we;
              dbus_oe <= req_we;
            end
          end
        end
        ST_BUS: begin
          if (cnt == CNT_LAST) begin
            // Last bus cycle ends here: capture read data and release the bus.
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= we_q ? '0 : DBUS;
            rsp_err   <= 1'b0;
            ABUS      <= IDLE_ADDR;
            WE        <= 1'b0;
            dbus_oe   <= 1'b0;
          end else begin
            cnt <= cnt - CNT_LAST;
          end
        end
        ST_RESP: begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          ABUS      <= IDLE_ADDR;
          WE        <= 1'b0;
          dbus_oe   <= 1'b0;
        end
      endcase
    end
  end

endmodule
